// File: rtl/pr_freeze_pkg.sv
// Shared types and default widths for the PR freeze sequencer.
package pr_freeze_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_FROZEN  = 3'd2,
    ST_PR_WAIT = 3'd3,
    ST_RELEASE = 3'd4
  } pr_frz_state_e;

  localparam int OUTST_W_DEF   = 8;
  localparam int TIMEOUT_W_DEF = 20;

endpackage

// File: rtl/pr_outst_counter.sv
// Saturating outstanding non-posted request counter for one PG port, with
// a sticky error flag raised on underflow or overflow.
module pr_outst_counter
  import pr_freeze_pkg::*;
#(
  parameter int W = OUTST_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  input  logic         err_clr,
  output logic [W-1:0] cnt,
  output logic         err
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         up, dn;

  always_comb begin
    up    = inc & ~dec;
    dn    = dec & ~inc;
    cnt_d = cnt_q;
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (clr) begin
      cnt_d = '0;
    end else if (up) begin
      if (&cnt_q) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (dn) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/pr_freeze_sequencer.sv
// Freeze/softreset sequencer for the PR slot: drains PG ports, freezes, waits
// for PR completion and releases. Optional drain timeout: PR_FREEZE_TIMEOUT_EN.
module pr_freeze_sequencer
  import pr_freeze_pkg::*;
#(
  parameter int          PG_NUM_PORTS  = 1,
  parameter int          OUTST_W       = OUTST_W_DEF,
  parameter int          TIMEOUT_W     = TIMEOUT_W_DEF,
  parameter int unsigned DRAIN_TIMEOUT = 20'hF_FFFF,
  parameter int          RST_HOLD      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze_req,
  input  logic                    pr_done,
  input  logic [PG_NUM_PORTS-1:0] np_req,
  input  logic [PG_NUM_PORTS-1:0] cpl_last,
  input  logic [PG_NUM_PORTS-1:0] tx_busy,
  output logic                    pr_freeze,
  output logic                    softreset,
  output logic                    freeze_ack,
  output logic                    drain_timeout,
  output logic [PG_NUM_PORTS-1:0] cnt_err,
  output logic [2:0]              state
);

  localparam int HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);

  pr_frz_state_e      state_q, state_d;
  logic               freeze_req_q;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               pr_freeze_q, pr_freeze_d;
  logic               softreset_q, softreset_d;
  logic               freeze_ack_q, freeze_ack_d;
  logic               drain_timeout_d;
  logic               freeze_edge;
  logic               drained;
  logic               cnt_clr;
  logic               err_clr;

  logic [OUTST_W-1:0]      cnt [PG_NUM_PORTS];
  logic [PG_NUM_PORTS-1:0] cnt_nz;

  generate
    for (genvar gi = 0; gi < PG_NUM_PORTS; gi++) begin : gen_cnt
      pr_outst_counter #(
        .W(OUTST_W)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (np_req[gi]),
        .dec     (cpl_last[gi]),
        .clr     (cnt_clr),
        .err_clr (err_clr),
        .cnt     (cnt[gi]),
        .err     (cnt_err[gi])
      );
      assign cnt_nz[gi] = |cnt[gi];
    end
  endgenerate

  assign freeze_edge = freeze_req & ~freeze_req_q;
  assign drained     = ~|cnt_nz & ~|tx_busy;

`ifdef PR_FREEZE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 tmo_hit;
  logic                 drain_timeout_q;

  assign tmo_hit = ((tmo_q + TIMEOUT_W'(1)) == TIMEOUT_W'(DRAIN_TIMEOUT));
`else
  logic tmo_hit;
  logic drain_timeout_q;

  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    drain_timeout_d = drain_timeout_q;
    cnt_clr         = 1'b0;
    err_clr         = 1'b0;
`ifdef PR_FREEZE_TIMEOUT_EN
    tmo_d           = '0;
`endif
    case (state_q)
      ST_RUN: begin
        if (freeze_edge) begin
          state_d         = ST_DRAIN;
          err_clr         = 1'b1;
          drain_timeout_d = 1'b0;
        end
      end
      ST_DRAIN: begin
`ifdef PR_FREEZE_TIMEOUT_EN
        tmo_d = tmo_q + TIMEOUT_W'(1);
`endif
        if (drained) begin
          state_d = ST_FROZEN;
        end else if (tmo_hit) begin
          state_d         = ST_FROZEN;
          drain_timeout_d = 1'b1;
        end
      end
      ST_FROZEN: begin
        state_d = ST_PR_WAIT;
      end
      ST_PR_WAIT: begin
        if (pr_done) begin
          // softreset discards whatever was still outstanding in the slot
          state_d = ST_RELEASE;
          hold_d  = HOLD_W'(RST_HOLD);
          cnt_clr = 1'b1;
        end
      end
      ST_RELEASE: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q <= HOLD_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    pr_freeze_d  = (state_d == ST_FROZEN) || (state_d == ST_PR_WAIT);
    softreset_d  = (state_d == ST_FROZEN) || (state_d == ST_PR_WAIT) ||
                   (state_d == ST_RELEASE);
    freeze_ack_d = (state_d == ST_PR_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      freeze_req_q    <= 1'b0;
      hold_q          <= '0;
      pr_freeze_q     <= 1'b0;
      softreset_q     <= 1'b0;
      freeze_ack_q    <= 1'b0;
      drain_timeout_q <= 1'b0;
`ifdef PR_FREEZE_TIMEOUT_EN
      tmo_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      freeze_req_q    <= freeze_req;
      hold_q          <= hold_d;
      pr_freeze_q     <= pr_freeze_d;
      softreset_q     <= softreset_d;
      freeze_ack_q    <= freeze_ack_d;
`ifdef PR_FREEZE_TIMEOUT_EN
      drain_timeout_q <= drain_timeout_d;
      tmo_q           <= tmo_d;
`else
      drain_timeout_q <= 1'b0;
`endif
    end
  end

`ifndef PR_FREEZE_TIMEOUT_EN
  logic unused_dt;
  assign unused_dt = drain_timeout_d;
`endif

  assign pr_freeze     = pr_freeze_q;
  assign softreset     = softreset_q;
  assign freeze_ack    = freeze_ack_q;
  assign drain_timeout = drain_timeout_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pr_freeze_sequencer.sv
// Scoreboard bench for pr_freeze_sequencer: directed stimulus pushes
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_pr_freeze_sequencer;

  localparam int NP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          freeze_req = 1'b0;
  logic          pr_done = 1'b0;
  logic [NP-1:0] np_req = '0;
  logic [NP-1:0] cpl_last = '0;
  logic [NP-1:0] tx_busy = '0;
  logic          pr_freeze, softreset, freeze_ack, drain_timeout;
  logic [NP-1:0] cnt_err;
  logic [2:0]    state;

  pr_freeze_sequencer #(
    .PG_NUM_PORTS (NP),
    .OUTST_W      (8),
    .TIMEOUT_W    (20),
    .DRAIN_TIMEOUT(64),
    .RST_HOLD     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze_req   (freeze_req),
    .pr_done      (pr_done),
    .np_req       (np_req),
    .cpl_last     (cpl_last),
    .tx_busy      (tx_busy),
    .pr_freeze    (pr_freeze),
    .softreset    (softreset),
    .freeze_ack   (freeze_ack),
    .drain_timeout(drain_timeout),
    .cnt_err      (cnt_err),
    .state        (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_STATE = 0, S_FRZ = 1, S_SRST = 2, S_ACK = 3, S_DT = 4, S_ERR = 5;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic string sig_name(int s);
    case (s)
      S_STATE: return "state";
      S_FRZ:   return "pr_freeze";
      S_SRST:  return "softreset";
      S_ACK:   return "freeze_ack";
      S_DT:    return "drain_timeout";
      default: return "cnt_err";
    endcase
  endfunction

  function automatic int actual(int s);
    case (s)
      S_STATE: return int'(state);
      S_FRZ:   return int'(pr_freeze);
      S_SRST:  return int'(softreset);
      S_ACK:   return int'(freeze_ack);
      S_DT:    return int'(drain_timeout);
      default: return int'(cnt_err);
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input int v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        int a;
        a = actual(exp_q[i].sig);
        n_cmp++;
        if (exp_q[i].cyc < cyc || a !== exp_q[i].val) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d (due %0d)",
                   sig_name(exp_q[i].sig), cyc, a, exp_q[i].val, exp_q[i].cyc);
        end else begin
          $display("check %s cyc=%0d got=%0d want=%0d",
                   sig_name(exp_q[i].sig), cyc, a, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  initial begin
    // Reset values
    for (int s = 0; s <= S_ERR; s++) expect_at(3, s, 0);
    goto(5);
    rst = 1'b0;

    // Idle slot: freeze edge at 10, pr_done at 50
    expect_at(11, S_STATE, 1);
    expect_at(12, S_STATE, 2);
    expect_at(12, S_FRZ, 1);
    expect_at(12, S_SRST, 1);
    expect_at(12, S_ACK, 0);
    expect_at(13, S_ACK, 1);
    expect_at(13, S_STATE, 3);
    expect_at(50, S_FRZ, 1);
    expect_at(51, S_FRZ, 0);
    expect_at(51, S_ACK, 0);
    expect_at(51, S_STATE, 4);
    expect_at(66, S_SRST, 1);
    expect_at(67, S_SRST, 0);
    expect_at(67, S_STATE, 0);
    goto(10); freeze_req = 1'b1;
    step();   freeze_req = 1'b0;
    goto(12);
    n_cmp++;
    if (pr_freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL direct pr_freeze cyc=%0d got=%0d want=1", cyc, pr_freeze);
    end else begin
      $display("check direct pr_freeze cyc=%0d got=%0d want=1", cyc, pr_freeze);
    end
    goto(13);
    n_cmp++;
    if (freeze_ack !== 1'b1 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL direct freeze_ack/state cyc=%0d got=%0d/%0d want=1/3", cyc, freeze_ack, state);
    end else begin
      $display("check direct freeze_ack/state cyc=%0d got=%0d/%0d want=1/3", cyc, freeze_ack, state);
    end
    goto(50); pr_done = 1'b1;
    step();   pr_done = 1'b0;
    goto(67);
    n_cmp++;
    if (softreset !== 1'b0) begin
      n_fail++;
      $display("FAIL direct softreset cyc=%0d got=%0d want=0", cyc, softreset);
    end else begin
      $display("check direct softreset cyc=%0d got=%0d want=0", cyc, softreset);
    end

    // Port 1 drains three requests; freeze_req held high throughout
    expect_at(85, S_STATE, 1);
    expect_at(151, S_STATE, 1);
    expect_at(186, S_STATE, 1);
    expect_at(187, S_STATE, 2);
    expect_at(187, S_DT, 0);
    expect_at(188, S_ACK, 1);
    expect_at(201, S_STATE, 4);
    expect_at(216, S_SRST, 1);
    expect_at(217, S_SRST, 0);
    expect_at(225, S_STATE, 0);
    goto(80);  np_req = 2'b10;
    goto(83);  np_req = 2'b00;
    goto(84);  freeze_req = 1'b1;
    goto(150); pr_done = 1'b1;
    step();    pr_done = 1'b0;
    goto(183); cpl_last = 2'b10;
    goto(186); cpl_last = 2'b00;
    goto(200); pr_done = 1'b1;
    step();    pr_done = 1'b0;
    goto(230); freeze_req = 1'b0;

    // Underflow on port 0, cleared by the next freeze edge
    expect_at(241, S_ERR, 1);
    expect_at(250, S_ERR, 1);
    expect_at(251, S_ERR, 0);
    expect_at(251, S_STATE, 1);
    expect_at(252, S_STATE, 2);
    expect_at(277, S_STATE, 0);
    goto(240); cpl_last = 2'b01;
    step();    cpl_last = 2'b00;
    goto(250); freeze_req = 1'b1;
    step();    freeze_req = 1'b0;
    goto(260); pr_done = 1'b1;
    step();    pr_done = 1'b0;

    // Simultaneous inc/dec at count 2, then drain gated by tx_busy
    expect_at(296, S_STATE, 1);
    expect_at(303, S_ERR, 0);
    expect_at(304, S_STATE, 1);
    expect_at(305, S_STATE, 2);
    expect_at(305, S_ERR, 0);
    expect_at(306, S_ACK, 1);
    goto(285); np_req = 2'b01;
    goto(287); np_req = 2'b00;
    goto(290); np_req = 2'b01; cpl_last = 2'b01;
    step();    np_req = 2'b00; cpl_last = 2'b00;
    goto(295); freeze_req = 1'b1;
    step();    freeze_req = 1'b0;
    goto(300); cpl_last = 2'b01; tx_busy = 2'b10;
    goto(302); cpl_last = 2'b00;
    goto(304); tx_busy = 2'b00;

    // Reset in PR_WAIT, then a stray pr_done
    expect_at(311, S_STATE, 0);
    expect_at(311, S_FRZ, 0);
    expect_at(311, S_SRST, 0);
    expect_at(311, S_ACK, 0);
    expect_at(316, S_STATE, 0);
    expect_at(316, S_FRZ, 0);
    expect_at(316, S_SRST, 0);
    goto(310); rst = 1'b1;
    step();    rst = 1'b0;
    goto(315); pr_done = 1'b1;
    step();    pr_done = 1'b0;

    // One completion never returns
`ifdef PR_FREEZE_TIMEOUT_EN
    expect_at(399, S_STATE, 1);
    expect_at(400, S_STATE, 2);
    expect_at(400, S_DT, 1);
    expect_at(420, S_DT, 1);
    expect_at(427, S_STATE, 0);
    expect_at(431, S_STATE, 1);
    expect_at(431, S_DT, 0);
    expect_at(432, S_STATE, 2);
    goto(330); np_req = 2'b01;
    step();    np_req = 2'b00;
    goto(335); freeze_req = 1'b1;
    step();    freeze_req = 1'b0;
    goto(410); pr_done = 1'b1;
    step();    pr_done = 1'b0;
    goto(430); freeze_req = 1'b1;
    step();    freeze_req = 1'b0;
`else
    expect_at(400, S_STATE, 1);
    expect_at(420, S_STATE, 1);
    expect_at(420, S_DT, 0);
    expect_at(426, S_STATE, 0);
    goto(330); np_req = 2'b01;
    step();    np_req = 2'b00;
    goto(335); freeze_req = 1'b1;
    step();    freeze_req = 1'b0;
    goto(425); rst = 1'b1;
    step();    rst = 1'b0;
`endif

    goto(450);
    @(posedge clk);
    #1;
    foreach (exp_q[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s never checked (due %0d)", sig_name(exp_q[i].sig), exp_q[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_freeze_sequencer.md
# pr_freeze_sequencer

Sequences the partial-reconfiguration freeze of the PR slot. It accepts a freeze request from the port-gasket CSR block and drains in-flight PCIe traffic on every PG port. It then asserts `pr_freeze` and `softreset` toward the PR slot, holds them until the PR engine reports completion, and releases them in a fixed order. It sits in the port gasket on the 2x PCIe clock, beside the PR slot whose freeze and reset inputs it drives.

## Interface
Parameters:
- `PG_NUM_PORTS`, 1: number of PG ports tracked.
- `OUTST_W`, 8: width of each per-port outstanding non-posted request counter.
- `TIMEOUT_W`, 20: width of the drain-timeout counter.
- `DRAIN_TIMEOUT`, 20'hF_FFFF: drain cycles allowed before forced freeze.
- `RST_HOLD`, 16: cycles `softreset` stays asserted after `pr_freeze` drops; must be ≥1.

Ports:
- `clk` in 1: PCIe 2x clock; one clock, all logic synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `freeze_req` in 1: CSR level; rising edge starts a freeze.
- `pr_done` in 1: one-cycle pulse from the PR engine when reconfiguration ends.
- `np_req` in PG_NUM_PORTS: per port, a non-posted request header accepted on TX this cycle.
- `cpl_last` in PG_NUM_PORTS: per port, the final completion for one request accepted on RX this cycle.
- `tx_busy` in PG_NUM_PORTS: per port, a TX packet is mid-transfer (sop seen, eop not yet).
- `pr_freeze` out 1: freeze to the PR slot.
- `softreset` out 1: AFU reset to the PR slot.
- `freeze_ack` out 1: slot frozen; PR may begin.
- `drain_timeout` out 1: sticky; the last drain ended by timeout.
- `cnt_err` out PG_NUM_PORTS: sticky per port; counter underflow or overflow.
- `state` out 3: current FSM encoding, for CSR readback.

## Operation
States and encodings: RUN=0, DRAIN=1, FROZEN=2, PR_WAIT=3, RELEASE=4.
- RUN → DRAIN on a `freeze_req` rising edge. The edge is detected with a registered copy of `freeze_req`; that copy resets to 0.
- DRAIN → FROZEN when every counter is 0 and `tx_busy` is all-zero. With the timeout feature compiled in, DRAIN → FROZEN also when the timeout expires; this sets `drain_timeout`.
- FROZEN → PR_WAIT unconditionally after one cycle. `freeze_ack` asserts on entry to PR_WAIT.
- PR_WAIT → RELEASE on `pr_done`. Entering RELEASE drops `pr_freeze` and `freeze_ack` and loads the hold counter with RST_HOLD.
- RELEASE → RUN when the hold counter reaches 0. `softreset` drops on entry to RUN.

Per-port outstanding counters:
- +1 on `np_req[j]`, −1 on `cpl_last[j]`; both in the same cycle gives no change.
- Decrement at 0 holds the counter at 0 and sets `cnt_err[j]`. Increment at all-ones holds the value and sets `cnt_err[j]`.
- Counters run in every state. Entering RELEASE clears them to 0, because `softreset` discards outstanding requests.

Output behaviour:
- `pr_freeze` = 1 in FROZEN, PR_WAIT. `softreset` = 1 in FROZEN, PR_WAIT, RELEASE.
- `drain_timeout` and `cnt_err` are sticky. They clear only on `rst` or on the next RUN → DRAIN transition.

Edge cases:
- `freeze_req` falling mid-sequence is ignored; the sequence always completes.
- `pr_done` outside PR_WAIT is ignored.
- A `freeze_req` edge in any state other than RUN is ignored. `freeze_req` still high on return to RUN starts no new freeze; only a fresh edge does.

## Timing
- Reset values: state=RUN, `pr_freeze`=0, `softreset`=0, `freeze_ack`=0, `drain_timeout`=0, `cnt_err`=0, all counters 0.
- All outputs are registered. `state` shows the new encoding the cycle after the transition condition.
- Freeze edge at cycle N: DRAIN from N+1. If already drained, FROZEN at N+2 with `pr_freeze` and `softreset` at 1, and `freeze_ack` at N+3.
- `pr_done` at cycle M: `pr_freeze`=0 at M+1. `softreset`=0 at M+1+RST_HOLD.
- The drain condition uses counter values registered in the previous cycle. A request accepted in the same cycle as the drain check is therefore counted on the next check.
- `rst` mid-sequence returns to RUN next cycle and deasserts all outputs.

## Configuration
- `PR_FREEZE_TIMEOUT_EN` defined:
  - A TIMEOUT_W counter clears on DRAIN entry and increments each DRAIN cycle.
  - Reaching DRAIN_TIMEOUT forces FROZEN and sets `drain_timeout`.
- Not defined:
  - DRAIN waits indefinitely.
  - No timeout counter is built.
  - `drain_timeout` is tied to 0.

## Structure
- Shared package `pr_freeze_pkg`:
  - State enum `pr_frz_state_e` with the encodings above.
  - Default localparams for OUTST_W and TIMEOUT_W.
- Sub-module `pr_outst_counter`: one saturating up/down counter with error flag and clear input. Instantiated PG_NUM_PORTS times in a generate loop.
- FSM, timeout counter and hold counter live in the top module.

## Test plan
- Idle slot, PG_NUM_PORTS=2, RST_HOLD=16: pulse `freeze_req` at cycle 10 → `pr_freeze`=1 at 12, `freeze_ack`=1 at 13. `pr_done` at 50 → `pr_freeze`=0 at 51, `softreset`=0 at 67.
- Port 1 issues 3 `np_req`, then returns 3 `cpl_last` 100 cycles later → remains in DRAIN until the cycle after the counter reads 0, then enters FROZEN. `drain_timeout`=0.
- `PR_FREEZE_TIMEOUT_EN`, DRAIN_TIMEOUT=64, one completion never returns → FROZEN after 64 DRAIN cycles. `drain_timeout`=1. Counter cleared to 0 on RELEASE.
- `cpl_last[0]` with counter at 0 → `cnt_err[0]`=1 and counter stays 0. Next freeze edge clears `cnt_err`.
- `np_req` and `cpl_last` on port 0 in the same cycle with counter at 2 → counter stays 2, no error.
- `rst` asserted in PR_WAIT → next cycle state=RUN and all outputs 0. A second `pr_done` is then ignored.
